// File: rtl/mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory request sequencer: FSM state encoding
// and default geometry of the 4096x16 basic-computer memory.
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

   localparam int MEM_ADDR_W = 12;
   localparam int MEM_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
// Request sequencer in front of the basic-computer `memory` block (single
// shared address for write port A / read port B). Takes read/write requests
// over valid/ready, drives the RAM write strobe, address and write data,
// holds the address across the synchronous read latency and returns read
// data over a valid/ready response channel.
//
// Ports
//   clock, reset_n            clock, async active-low reset
//   req_valid/req_ready       request handshake
//   req_write/addr/wdata      request payload, sampled on handshake
//   rsp_valid/rsp_ready       read response handshake
//   rsp_rdata                 captured read word
//   mem_write/addr/wdata      to memory memoryWrite / Adrss / InpData
//   mem_rdata                 from memory OutData
//   busy                      high whenever not IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; address/data latched on handshake
// WRITE | single-cycle write strobe to the RAM
// READ  | address held while the RAM read latency elapses
// RESP  | read word presented until the consumer takes it
// ----------------------------------------------------------------------------
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W       = MEM_ADDR_W,
   parameter int DATA_W       = MEM_DATA_W,
   parameter int READ_LATENCY = 1,
   parameter int CNT_W        = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              w_accept;
   logic              w_lat_done;

   assign w_accept   = (r_state == IDLE) && req_valid;
   // The counter starts at 0 on the handshake edge, so this fires
   // READ_LATENCY + 1 edges after the request was accepted.
   assign w_lat_done = (r_state == READ) && (r_cnt == CNT_W'(READ_LATENCY));

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_state_nxt = req_write ? WRITE : READ;
            end
         end
         WRITE: w_state_nxt = IDLE;
         READ: begin
            if (w_lat_done) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // outputs decoded from the registered state only, so request inputs
   // can never glitch the RAM write strobe
   always_comb begin
      req_ready = 1'b0;
      busy      = 1'b1;
      mem_write = 1'b0;
      rsp_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         WRITE: mem_write = 1'b1;
         READ:  ;
         RESP:  rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // datapath: address/data latch, latency counter, response capture
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cnt       <= '0;
         r_rsp_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_mem_addr  <= req_addr;
            r_mem_wdata <= req_wdata;
            r_cnt       <= '0;
         end else if (r_state == READ) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_lat_done) begin
            r_rsp_rdata <= mem_rdata;
         end
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   typedef struct {
      logic [11:0] a;
      logic [15:0] d;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset_n;

   // default-latency instance
   logic        req_valid, req_ready, req_write;
   logic [11:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_rdata;
   logic        mem_write;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;

   // READ_LATENCY = 3 instance
   logic        req_valid_l3, req_ready_l3, req_write_l3;
   logic [11:0] req_addr_l3;
   logic [15:0] req_wdata_l3;
   logic        rsp_valid_l3, rsp_ready_l3;
   logic [15:0] rsp_rdata_l3;
   logic        mem_write_l3;
   logic [11:0] mem_addr_l3;
   logic [15:0] mem_wdata_l3;
   logic [15:0] mem_rdata_l3;
   logic        busy_l3;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int wcount   = 0;

   wr_t         wq[$];
   logic [15:0] rq[$];
   logic [15:0] ref_mem [int];
   wr_t         w_e;
   logic [15:0] r_e;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   mem_access_ctrl u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   mem_access_ctrl #(.READ_LATENCY(3), .CNT_W(3)) u_dut_l3 (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid_l3),
      .req_ready (req_ready_l3),
      .req_write (req_write_l3),
      .req_addr  (req_addr_l3),
      .req_wdata (req_wdata_l3),
      .rsp_valid (rsp_valid_l3),
      .rsp_ready (rsp_ready_l3),
      .rsp_rdata (rsp_rdata_l3),
      .mem_write (mem_write_l3),
      .mem_addr  (mem_addr_l3),
      .mem_wdata (mem_wdata_l3),
      .mem_rdata (mem_rdata_l3),
      .busy      (busy_l3)
   );

   // behavioural RAMs: shared address, synchronous read
   logic [15:0] mem0 [0:4095];
   always @(posedge clock) begin
      if (mem_write) mem0[mem_addr] <= mem_wdata;
      mem_rdata <= mem0[mem_addr];
   end

   logic [15:0] mem1 [0:4095];
   logic [15:0] p1_0, p1_1, p1_2;
   always @(posedge clock) begin
      if (mem_write_l3) mem1[mem_addr_l3] <= mem_wdata_l3;
      p1_0 <= mem1[mem_addr_l3];
      p1_1 <= p1_0;
      p1_2 <= p1_1;
   end
   assign mem_rdata_l3 = p1_2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: write strobes and accepted responses against queued expectations
   always @(negedge clock) begin
      if (reset_n) begin
         if (mem_write) begin
            wcount++;
            chk("wr_expected", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
               w_e = wq.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(w_e.a));
               chk("wr_data", 32'(mem_wdata), 32'(w_e.d));
            end
         end
         if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(rq.size() > 0), 32'd1);
            if (rq.size() > 0) begin
               r_e = rq.pop_front();
               chk("rsp_data", 32'(rsp_rdata), 32'(r_e));
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
   endtask

   // returns 1 ns after the handshake edge
   task automatic issue(input logic w, input logic [11:0] a, input logic [15:0] d,
                        input bit track);
      wait_ready();
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      if (track) begin
         if (w) begin
            wq.push_back('{a: a, d: d});
            ref_mem[int'(a)] = d;
         end else begin
            rq.push_back(ref_mem[int'(a)]);
         end
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 12) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   initial begin
      int n;
      int prev_cyc;
      int base_w;

      reset_n      = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      rsp_ready    = 1'b1;
      req_valid_l3 = 1'b0;
      req_write_l3 = 1'b0;
      req_addr_l3  = '0;
      req_wdata_l3 = '0;
      rsp_ready_l3 = 1'b1;
      prev_cyc     = 0;

      repeat (2) @(posedge clock);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // preload through the controller
      issue(1'b1, 12'hFFF, 16'h0A5A, 1'b1);
      issue(1'b1, 12'h055, 16'h1111, 1'b1);

      // write then read, same address
      issue(1'b1, 12'h123, 16'hBEEF, 1'b1);
      chk("wr_strobe_on",  32'(mem_write), 32'd1);
      chk("wr_addr_0x123", 32'(mem_addr),  32'h123);
      chk("wr_data_beef",  32'(mem_wdata), 32'hBEEF);
      chk("wr_busy",       32'(busy),      32'd1);
      @(posedge clock); #1;
      chk("wr_strobe_off", 32'(mem_write), 32'd0);
      issue(1'b0, 12'h123, 16'h0, 1'b1);
      chk("rd_no_strobe", 32'(mem_write), 32'd0);
      wait_rsp(n);
      chk("rd_latency", 32'(n), 32'd2);
      chk("rd_data_beef", 32'(rsp_rdata), 32'hBEEF);
      @(posedge clock); #1;

      // backpressure on 0xFFF
      rsp_ready = 1'b0;
      issue(1'b0, 12'hFFF, 16'h0, 1'b1);
      wait_rsp(n);
      chk("bp_latency", 32'(n), 32'd2);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_rdata", 32'(rsp_rdata), 32'h0A5A);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(posedge clock); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      chk("bp_rsp_drop",  32'(rsp_valid), 32'd0);
      chk("bp_ready_ret", 32'(req_ready), 32'd1);

      // held request: four writes with req_valid never dropping
      base_w    = wcount;
      req_valid = 1'b1;
      req_write = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_ready();
         req_addr  = 12'(k);
         req_wdata = 16'hC000 + 16'(k);
         wq.push_back('{a: 12'(k), d: 16'hC000 + 16'(k)});
         ref_mem[k] = 16'hC000 + 16'(k);
         @(posedge clock); #1;
         if (k > 0) chk("held_spacing", 32'(cyc - prev_cyc), 32'd2);
         prev_cyc = cyc;
         chk("held_strobe", 32'(mem_write), 32'd1);
         if (k == 3) req_valid = 1'b0;
      end
      repeat (3) @(posedge clock);
      #1;
      chk("held_pulses", 32'(wcount - base_w), 32'd4);
      issue(1'b0, 12'h002, 16'h0, 1'b1);
      wait_rsp(n);
      chk("held_readback", 32'(rsp_rdata), 32'hC002);
      @(posedge clock); #1;

      // reset in the middle of a read
      issue(1'b0, 12'h123, 16'h0, 1'b0);
      #2;
      chk("mid_rd_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      wq.delete();
      rq.delete();
      #1;
      chk("mid_rd_req_ready", 32'(req_ready), 32'd1);
      chk("mid_rd_busy_rst",  32'(busy),      32'd0);
      chk("mid_rd_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rd_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("mid_rd_mem_addr",  32'(mem_addr),  32'd0);
      chk("mid_rd_mem_wdata", 32'(mem_wdata), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
         chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      end

      // reset during the write cycle aborts the write
      issue(1'b1, 12'h055, 16'h2222, 1'b0);
      chk("abort_strobe_on", 32'(mem_write), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_strobe_off", 32'(mem_write), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      issue(1'b0, 12'h055, 16'h0, 1'b1);
      wait_rsp(n);
      chk("abort_readback", 32'(rsp_rdata), 32'h1111);
      @(posedge clock); #1;

      // READ_LATENCY = 3 instance
      req_valid_l3 = 1'b1;
      req_write_l3 = 1'b1;
      req_addr_l3  = 12'h010;
      req_wdata_l3 = 16'h1234;
      @(posedge clock); #1;
      req_valid_l3 = 1'b0;
      chk("l3_wr_strobe", 32'(mem_write_l3), 32'd1);
      @(posedge clock); #1;
      req_valid_l3 = 1'b1;
      req_write_l3 = 1'b0;
      @(posedge clock); #1;
      req_valid_l3 = 1'b0;
      n = 0;
      while (!rsp_valid_l3 && n < 12) begin
         chk("l3_addr_hold", 32'(mem_addr_l3), 32'h010);
         @(posedge clock); #1;
         n++;
      end
      chk("l3_latency", 32'(n), 32'd4);
      chk("l3_rdata",   32'(rsp_rdata_l3), 32'h1234);
      @(posedge clock); #1;
      chk("l3_rsp_drop", 32'(rsp_valid_l3), 32'd0);
      chk("l3_ready",    32'(req_ready_l3), 32'd1);

      repeat (2) @(posedge clock);
      #1;
      chk("wq_drained", 32'(wq.size()), 32'd0);
      chk("rq_drained", 32'(rq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
